instruction_fetch: RTL

Fetch stage of the LEGv8 datapath: owns the PC and issues word fetches to instruction memory over a request/response handshake. It presents each fetched instruction, its PC and its 11-bit opcode field to the decode controller. It resolves branch redirects from `isZeroBranch`, `isUnconBranch` and the ALU zero flag, and squashes wrong-path fetches. A one-entry skid buffer absorbs a response that arrives while decode is stalled.

---
 rtl/ifetch_pkg.sv | 18 +
 rtl/fetch_skid_buffer.sv | 60 ++++++
 rtl/instruction_fetch.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the LEGv8 instruction fetch stage.
package ifetch_pkg;

  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 21;
  localparam int unsigned OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;
  localparam int unsigned PC_STEP    = 4;

  // Fetch sequencer states; ERROR is only reachable with IFETCH_ALIGN_CHECK_EN.
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    BLOCKED = 2'd2,
    ERROR   = 2'd3
  } ifetch_state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {instr, pc} holding register for a response that arrives while
// decode is stalled on the output register.
//   load_i   : capture instr_i/pc_i and mark full
//   unload_i : entry has moved to the output register, mark empty
//   flush_i  : redirect squash, mark empty (wins over load/unload)
//   full_o, instr_o, pc_o : held entry
module fetch_skid_buffer
  import ifetch_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic                unload_i,
  input  logic                flush_i,
  input  logic [INSTR_W-1:0]  instr_i,
  input  logic [PC_WIDTH-1:0] pc_i,
  output logic                full_o,
  output logic [INSTR_W-1:0]  instr_o,
  output logic [PC_WIDTH-1:0] pc_o
);

  logic                full_q, full_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;

  // Next entry: flush > load > unload.
  always_comb begin
    full_d  = full_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush_i) begin
      full_d = 1'b0;
    end else if (load_i) begin
      full_d  = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end else if (unload_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      full_q  <= full_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign full_o  = full_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// LEGv8 fetch stage: owns the PC, issues one-outstanding word fetches, and
// presents {instr, instr_pc, opcode} to decode. Branch redirects squash the
// output, the skid entry and any in-flight response.
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   imem_req/imem_addr/imem_ready   : fetch request handshake (addr = PC)
//   imem_rvalid/imem_rdata          : fetch response
//   stall                           : decode cannot consume this cycle
//   isZeroBranch/isUnconBranch/aluZero/br_target : branch resolution
//   instr_valid/instr/instr_pc/opcode : instruction to decode
//   misalign_err                    : sticky misaligned redirect flag
// Build option: define IFETCH_ALIGN_CHECK_EN to trap misaligned redirect
// targets into ERROR; otherwise target bits [1:0] are forced to zero.
module instruction_fetch
  import ifetch_pkg::*;
#(
  parameter int unsigned         PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imem_req,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic                 imem_ready,
  input  logic                 imem_rvalid,
  input  logic [INSTR_W-1:0]   imem_rdata,
  input  logic                 stall,
  input  logic                 isZeroBranch,
  input  logic                 isUnconBranch,
  input  logic                 aluZero,
  input  logic [PC_WIDTH-1:0]  br_target,
  output logic                 instr_valid,
  output logic [INSTR_W-1:0]   instr,
  output logic [PC_WIDTH-1:0]  instr_pc,
  output logic [OPCODE_W-1:0]  opcode,
  output logic                 misalign_err
);

  ifetch_state_e       state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pc_issued_q, pc_issued_d;
  logic                drop_q, drop_d;
  logic                req_q, req_d;
  logic                valid_q, valid_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [PC_WIDTH-1:0] ipc_q, ipc_d;

  logic                skid_load, skid_unload, skid_flush, skid_full;
  logic [INSTR_W-1:0]  skid_instr;
  logic [PC_WIDTH-1:0] skid_pc;

  logic                take_c, xfer_c, consume_c, outstanding_c;
  logic [PC_WIDTH-1:0] target_c;

  assign take_c    = isUnconBranch | (isZeroBranch & aluZero);
  assign xfer_c    = req_q & imem_ready;
  assign consume_c = valid_q & ~stall;
  // A request is still in flight after this edge if one transfers now, or
  // the pending one has not answered yet.
  assign outstanding_c = xfer_c | ((state_q == WAIT) & ~imem_rvalid);

`ifdef IFETCH_ALIGN_CHECK_EN
  logic misalign_c;
  logic err_q, err_d;
  assign target_c     = br_target;
  assign misalign_c   = |br_target[1:0];
  assign misalign_err = err_q;
`else
  assign target_c     = br_target & ~PC_WIDTH'(2'b11);
  assign misalign_err = 1'b0;
`endif

  fetch_skid_buffer #(.PC_WIDTH(PC_WIDTH)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .flush_i  (skid_flush),
    .instr_i  (imem_rdata),
    .pc_i     (pc_issued_q),
    .full_o   (skid_full),
    .instr_o  (skid_instr),
    .pc_o     (skid_pc)
  );

  // Next-state, PC and output register control; redirect overrides last.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_issued_d = pc_issued_q;
    drop_d      = drop_q;
    valid_d     = valid_q & ~consume_c;
    instr_d     = instr_q;
    ipc_d       = ipc_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_flush  = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
    err_d       = err_q;
`endif

    case (state_q)
      FETCH: begin
        if (xfer_c) begin
          pc_issued_d = pc_q;
          pc_d        = pc_q + PC_WIDTH'(PC_STEP);
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = FETCH;
          end else if (!valid_q || !stall) begin
            valid_d = 1'b1;
            instr_d = imem_rdata;
            ipc_d   = pc_issued_q;
            state_d = FETCH;
          end else begin
            skid_load = 1'b1;
            state_d   = BLOCKED;
          end
        end
      end
      BLOCKED: begin
        if (consume_c && skid_full) begin
          valid_d     = 1'b1;
          instr_d     = skid_instr;
          ipc_d       = skid_pc;
          skid_unload = 1'b1;
          state_d     = FETCH;
        end
      end
      ERROR: begin
      end
    endcase

    if (take_c && (state_q != ERROR)) begin
      valid_d     = 1'b0;
      instr_d     = instr_q;
      ipc_d       = ipc_q;
      skid_flush  = 1'b1;
      skid_load   = 1'b0;
      skid_unload = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
      if (misalign_c) begin
        err_d   = 1'b1;
        drop_d  = 1'b0;
        state_d = ERROR;
      end else begin
`endif
        pc_d    = target_c;
        drop_d  = outstanding_c;
        state_d = outstanding_c ? WAIT : FETCH;
`ifdef IFETCH_ALIGN_CHECK_EN
      end
`endif
    end

    req_d = (state_d == FETCH);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // PC, request and output registers; req_q stays low through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      pc_issued_q <= '0;
      drop_q      <= 1'b0;
      req_q       <= 1'b0;
      valid_q     <= 1'b0;
      instr_q     <= '0;
      ipc_q       <= '0;
    end else begin
      pc_q        <= pc_d;
      pc_issued_q <= pc_issued_d;
      drop_q      <= drop_d;
      req_q       <= req_d;
      valid_q     <= valid_d;
      instr_q     <= instr_d;
      ipc_q       <= ipc_d;
    end
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`endif

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign opcode      = instr_q[OPCODE_MSB:OPCODE_LSB];

endmodule
